muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//   Iterative multiply/divide sequencer that executes MUL, UMULL, SMULL and UDIV on behalf of the
//   multicycle main FSM, which issues a one-cycle Start and waits on Busy/Done.
//   Implements the radix-2 shift-add multiply and restoring divide with a counter-driven FSM.
//   Results are registered and held until the next accepted Start, so the writeback states can
//   read them at leisure.
// PARAMETERS
//   WIDTH   32   operand width in bits; WIDTH >= 4; the iteration counter is $clog2(WIDTH) bits
// PORTS
//   clk       in   1        clock; all state changes on the rising edge
//   reset     in   1        synchronous, active-high reset
//   Start     in   1        request; sampled only in IDLE or DONE
//   MdOp      in   2        00 MUL (low word), 01 UMULL, 10 SMULL, 11 UDIV
//   SrcA      in   WIDTH    multiplicand / dividend; latched with Start
//   SrcB      in   WIDTH    multiplier / divisor; latched with Start
//   Busy      out  1        1 in RUN and FIX
//   Done      out  1        1 for exactly one cycle in DONE
//   ResultLo  out  WIDTH    low product word / quotient
//   ResultHi  out  WIDTH    high product word / remainder; 0 for MUL
//   DivZero   out  1        UDIV with SrcB==0; valid with Done, held with results
// BEHAVIOUR
//   Reset: state=IDLE; Busy=0, Done=0, DivZero=0, ResultLo=0, ResultHi=0; counter and operand
//     registers are cleared.
//   Reset mid-operation: the operation is abandoned and no Done is produced.
//   States and transitions:
//     IDLE -> RUN on Start. Exception: UDIV with SrcB==0 goes IDLE -> DONE.
//     RUN  stays RUN while cnt != WIDTH-1, incrementing cnt each cycle; -> FIX when cnt == WIDTH-1.
//       RUN lasts exactly WIDTH cycles.
//     FIX  -> DONE (one cycle). Applies the SMULL sign correction and loads ResultLo/ResultHi.
//     DONE -> RUN if Start (back-to-back issue), otherwise -> IDLE.
//       The DONE-state exception for UDIV with SrcB==0 applies here too: DONE -> DONE.
//   Start is ignored in RUN and FIX. MdOp, SrcA and SrcB are don't-care outside Start cycles.
//   Latency (Start cycle = cycle 0):
//     Busy is high in cycles 1..WIDTH+1; Done is high in cycle WIDTH+2.
//     Divide-by-zero: Done is high in cycle 1 and Busy never rises.
//   Multiply:
//     2*WIDTH-bit accumulator; each RUN cycle, if the multiplier LSB is 1, add the multiplicand
//       into the upper half, then shift the whole accumulator right by 1 (the carry is kept).
//     SMULL: on Start, latch |SrcA| and |SrcB| as unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1)
//       fits) and latch neg = SrcA[MSB]^SrcB[MSB].
//     FIX: the 2*WIDTH-bit product is two's-complement negated if neg.
//     MUL: ResultLo = low WIDTH bits; ResultHi = 0.
//   Divide (unsigned, restoring):
//     Each RUN cycle, shift {rem,quo} left by 1 and trial-subtract the divisor from rem.
//     If there is no borrow, keep the difference and set quo LSB = 1.
//     Result: ResultLo = quotient, ResultHi = remainder.
//     Divide-by-zero: ResultLo = all ones, ResultHi = SrcA, DivZero = 1.
//   Results:
//     ResultLo, ResultHi and DivZero update only on entry to DONE and are held through DONE, IDLE
//       and any following RUN/FIX, until the next DONE entry.
//     DivZero is cleared on the next normal completion.
// TESTING
//   Timing: MUL SrcA=7, SrcB=6 (WIDTH=32) -> Done exactly at cycle 34; ResultLo=42, ResultHi=0;
//     Busy high in cycles 1..33.
//   UMULL 0xFFFFFFFF*0xFFFFFFFF -> ResultHi=0xFFFFFFFE, ResultLo=0x00000001.
//   SMULL -> Hi:Lo values:
//     SMULL -3*5 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFF1.
//     SMULL 0x80000000*0x80000000 -> ResultHi=0x40000000, ResultLo=0.
//   UDIV cases:
//     UDIV 100/7 -> ResultLo=14, ResultHi=2, DivZero=0.
//     UDIV 5/0 -> Done in cycle 1, ResultLo=0xFFFFFFFF, ResultHi=5, DivZero=1.
//   Start pulses and back-to-back issue:
//     Start pulsed in cycle 10 of a running MUL -> ignored; exactly one Done.
//     Start held during DONE -> new op accepted; Done period = 34 cycles.
//   Reset asserted at cycle 15 of a UMULL -> next cycle IDLE, all outputs 0, no Done afterwards.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: radix-2 shift-add multiply (MUL, UMULL, SMULL)
// and restoring unsigned divide (UDIV). Results are registered on DONE entry and held
// until the next completion.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MdOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivZero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_UDIV  = 2'b11
  } op_e;

  state_e           state;
  op_e              op;
  logic [CW-1:0]    cnt;
  // Multiply: {partial high, multiplier/low product}. Divide: {remainder, quotient}.
  logic [AW-1:0]    acc;
  // Multiplicand (multiply) or divisor (divide).
  logic [WIDTH-1:0] opb;
  logic             neg;

  // Start-time operand preparation
  op_e              start_op;
  logic             start_dz;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] ld_lo;
  logic [WIDTH-1:0] ld_opb;
  logic             ld_neg;

  // Per-iteration datapath
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_borrow;
  logic [AW-1:0]    acc_step;
  logic [AW-1:0]    prod_fix;

  // Select what gets latched when a Start is accepted
  always_comb begin
    start_op = op_e'(MdOp);
    start_dz = (start_op == OP_UDIV) && (SrcB == '0);
    a_abs    = SrcA[WIDTH-1] ? -SrcA : SrcA;
    b_abs    = SrcB[WIDTH-1] ? -SrcB : SrcB;
    ld_lo    = SrcB;
    ld_opb   = SrcA;
    ld_neg   = 1'b0;
    case (start_op)
      OP_SMULL: begin
        ld_lo  = b_abs;
        ld_opb = a_abs;
        ld_neg = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
      end
      OP_UDIV: begin
        ld_lo  = SrcA;
        ld_opb = SrcB;
      end
      default: ;
    endcase
  end

  // One shift-add or restoring-divide step, plus the final sign fix
  always_comb begin
    mul_addend = acc[0] ? opb : '0;
    mul_sum    = {1'b0, acc[AW-1:WIDTH]} + {1'b0, mul_addend};
    div_shift  = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opb};
    div_borrow = div_diff[WIDTH];
    if (op == OP_UDIV) begin
      if (div_borrow) begin
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    prod_fix = neg ? -acc : acc;
  end

  // Sequencer FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op       <= OP_MUL;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      neg      <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
      DivZero  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            op  <= start_op;
            acc <= {WIDTH'(0), ld_lo};
            opb <= ld_opb;
            neg <= ld_neg;
            cnt <= '0;
            if (start_dz) begin
              // Divide by zero completes immediately without iterating
              state    <= S_DONE;
              Busy     <= 1'b0;
              Done     <= 1'b1;
              ResultLo <= '1;
              ResultHi <= SrcA;
              DivZero  <= 1'b1;
            end else begin
              state <= S_RUN;
              Busy  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          acc <= acc_step;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_FIX: begin
          state   <= S_DONE;
          Busy    <= 1'b0;
          Done    <= 1'b1;
          DivZero <= 1'b0;
          case (op)
            OP_UDIV: begin
              ResultLo <= acc[WIDTH-1:0];
              ResultHi <= acc[AW-1:WIDTH];
            end
            OP_MUL: begin
              ResultLo <= prod_fix[WIDTH-1:0];
              ResultHi <= '0;
            end
            default: begin
              ResultLo <= prod_fix[WIDTH-1:0];
              ResultHi <= prod_fix[AW-1:WIDTH];
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq (WIDTH = 32).
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [1:0]   MdOp;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] ResultLo;
  logic [W-1:0] ResultHi;
  logic         DivZero;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .MdOp     (MdOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Busy     (Busy),
    .Done     (Done),
    .ResultLo (ResultLo),
    .ResultHi (ResultHi),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from the current cycle; lat = cycles until Done, -1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    MdOp  = op;
    SrcA  = a;
    SrcB  = b;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    MdOp  = ~op;
    SrcA  = 32'hDEAD_BEEF;
    SrcB  = 32'h0BAD_F00D;
    lat   = 1;
    while (Done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    if (Done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b0;
    MdOp  = 2'b00;
    SrcA  = '0;
    SrcB  = '0;
    repeat (2) tick();
    vecs++;
    if ({Busy, Done, DivZero, ResultHi, ResultLo} !== '0) begin
      errs++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               Busy, Done, DivZero, ResultHi, ResultLo);
    end
    reset = 1'b0;
    repeat (3) tick();
    vecs++;
    if ({Busy, Done, DivZero, ResultHi, ResultLo} !== '0) begin
      errs++;
      $display("FAIL idle_after_reset: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               Busy, Done, DivZero, ResultHi, ResultLo);
    end
  endtask

  task automatic test_mul_timing();
    int bad = 0;
    MdOp  = 2'b00;
    SrcA  = 32'd7;
    SrcB  = 32'd6;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    SrcA  = 32'hFFFF_FFFF;
    SrcB  = 32'hFFFF_FFFF;
    for (int c = 1; c <= 33; c++) begin
      if (Busy !== 1'b1 || Done !== 1'b0) bad++;
      tick();
    end
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL mul_busy_window: got %0d bad cycles in 1..33 want 0", bad);
    end
    vecs++;
    if ({Done, Busy, DivZero, ResultHi, ResultLo} !== {3'b100, 32'd0, 32'd42}) begin
      errs++;
      $display("FAIL mul_done_c34: got done=%b busy=%b dz=%b hi=%h lo=%h want done=1 busy=0 dz=0 hi=0 lo=2a",
               Done, Busy, DivZero, ResultHi, ResultLo);
    end
    tick();
    vecs++;
    if ({Done, Busy, ResultLo} !== {2'b00, 32'd42}) begin
      errs++;
      $display("FAIL mul_done_one_cycle: got done=%b busy=%b lo=%h want done=0 busy=0 lo=2a",
               Done, Busy, ResultLo);
    end
  endtask

  task automatic test_multiply();
    vec_t t [6];
    int   lat;
    t[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    t[1] = '{2'b10, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    t[2] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    t[3] = '{2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    t[4] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000};
    t[5] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'h0000_0000, 32'hFFFF_FFF1};
    for (int i = 0; i < 6; i++) begin
      run_op(t[i].op, t[i].a, t[i].b, lat);
      vecs++;
      if (lat !== 34 || {ResultHi, ResultLo, DivZero} !== {t[i].hi, t[i].lo, 1'b0}) begin
        errs++;
        $display("FAIL mul_vec%0d: got lat=%0d hi=%h lo=%h dz=%b want lat=34 hi=%h lo=%h dz=0",
                 i, lat, ResultHi, ResultLo, DivZero, t[i].hi, t[i].lo);
      end
      tick();
    end
  endtask

  task automatic test_divide();
    vec_t t [5];
    int   lat;
    t[0] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    t[1] = '{2'b11, 32'd7,         32'd100,       32'd7,         32'd0};
    t[2] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
    t[3] = '{2'b11, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF};
    t[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(t[i].op, t[i].a, t[i].b, lat);
      vecs++;
      if (lat !== 34 || {ResultHi, ResultLo, DivZero} !== {t[i].hi, t[i].lo, 1'b0}) begin
        errs++;
        $display("FAIL div_vec%0d: got lat=%0d rem=%h quo=%h dz=%b want lat=34 rem=%h quo=%h dz=0",
                 i, lat, ResultHi, ResultLo, DivZero, t[i].hi, t[i].lo);
      end
      tick();
    end
    run_op(2'b11, 32'd5, 32'd0, lat);
    vecs++;
    if (lat !== 1 || {Busy, DivZero, ResultHi, ResultLo} !== {2'b01, 32'd5, 32'hFFFF_FFFF}) begin
      errs++;
      $display("FAIL div_zero: got lat=%0d busy=%b dz=%b hi=%h lo=%h want lat=1 busy=0 dz=1 hi=5 lo=ffffffff",
               lat, Busy, DivZero, ResultHi, ResultLo);
    end
    tick();
    vecs++;
    if ({Busy, Done, DivZero, ResultLo} !== {3'b001, 32'hFFFF_FFFF}) begin
      errs++;
      $display("FAIL div_zero_hold: got busy=%b done=%b dz=%b lo=%h want busy=0 done=0 dz=1 lo=ffffffff",
               Busy, Done, DivZero, ResultLo);
    end
    run_op(2'b11, 32'd100, 32'd7, lat);
    vecs++;
    if (lat !== 34 || {DivZero, ResultHi, ResultLo} !== {1'b0, 32'd2, 32'd14}) begin
      errs++;
      $display("FAIL div_zero_clear: got lat=%0d dz=%b hi=%h lo=%h want lat=34 dz=0 hi=2 lo=e",
               lat, DivZero, ResultHi, ResultLo);
    end
    tick();
  endtask

  task automatic test_hold();
    int lat;
    repeat (5) tick();
    vecs++;
    if ({ResultHi, ResultLo} !== {32'd2, 32'd14}) begin
      errs++;
      $display("FAIL hold_idle: got hi=%h lo=%h want hi=2 lo=e", ResultHi, ResultLo);
    end
    MdOp  = 2'b01;
    SrcA  = 32'd3;
    SrcB  = 32'd4;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    vecs++;
    if ({Busy, ResultHi, ResultLo} !== {1'b1, 32'd2, 32'd14}) begin
      errs++;
      $display("FAIL hold_run: got busy=%b hi=%h lo=%h want busy=1 hi=2 lo=e", Busy, ResultHi, ResultLo);
    end
    lat = 5;
    while (Done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    vecs++;
    if (lat !== 34 || {ResultHi, ResultLo} !== {32'd0, 32'd12}) begin
      errs++;
      $display("FAIL hold_next_op: got lat=%0d hi=%h lo=%h want lat=34 hi=0 lo=c", lat, ResultHi, ResultLo);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int           n_done = 0;
    int           first  = -1;
    logic [W-1:0] lo_at  = '0;
    logic         dz_at  = 1'b1;
    MdOp  = 2'b00;
    SrcA  = 32'd9;
    SrcB  = 32'd9;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (Done === 1'b1) begin
        n_done++;
        if (first < 0) begin
          first = c;
          lo_at = ResultLo;
          dz_at = DivZero;
        end
      end
      if (c == 10) begin
        Start = 1'b1;
        MdOp  = 2'b11;
        SrcA  = 32'd5;
        SrcB  = 32'd0;
      end else begin
        Start = 1'b0;
      end
      tick();
    end
    vecs++;
    if (n_done !== 1 || first !== 34 || lo_at !== 32'd81 || dz_at !== 1'b0) begin
      errs++;
      $display("FAIL ignored_start: got dones=%0d first=%0d lo=%h dz=%b want dones=1 first=34 lo=51 dz=0",
               n_done, first, lo_at, dz_at);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(2'b01, 32'h10, 32'h20, lat);
    vecs++;
    if (lat !== 34 || {ResultHi, ResultLo} !== {32'd0, 32'h200}) begin
      errs++;
      $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h want lat=34 hi=0 lo=200", lat, ResultHi, ResultLo);
    end
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, lat);
    vecs++;
    if (lat !== 34 || {ResultHi, ResultLo} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
      errs++;
      $display("FAIL b2b_period: got lat=%0d hi=%h lo=%h want lat=34 hi=ffffffff lo=fffffff1",
               lat, ResultHi, ResultLo);
    end
    run_op(2'b11, 32'h1234, 32'd0, lat);
    vecs++;
    if (lat !== 1 || {Busy, DivZero, ResultHi, ResultLo} !== {2'b01, 32'h1234, 32'hFFFF_FFFF}) begin
      errs++;
      $display("FAIL b2b_divzero: got lat=%0d busy=%b dz=%b hi=%h lo=%h want lat=1 busy=0 dz=1 hi=1234 lo=ffffffff",
               lat, Busy, DivZero, ResultHi, ResultLo);
    end
    run_op(2'b11, 32'd9, 32'd0, lat);
    vecs++;
    if (lat !== 1 || {Busy, DivZero, ResultHi} !== {2'b01, 32'd9}) begin
      errs++;
      $display("FAIL b2b_divzero_again: got lat=%0d busy=%b dz=%b hi=%h want lat=1 busy=0 dz=1 hi=9",
               lat, Busy, DivZero, ResultHi);
    end
    run_op(2'b11, 32'd100, 32'd7, lat);
    vecs++;
    if (lat !== 34 || {DivZero, ResultHi, ResultLo} !== {1'b0, 32'd2, 32'd14}) begin
      errs++;
      $display("FAIL b2b_after_divzero: got lat=%0d dz=%b hi=%h lo=%h want lat=34 dz=0 hi=2 lo=e",
               lat, DivZero, ResultHi, ResultLo);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n_act = 0;
    MdOp  = 2'b01;
    SrcA  = 32'hFFFF_FFFF;
    SrcB  = 32'hFFFF_FFFF;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    vecs++;
    if ({Busy, Done, DivZero, ResultHi, ResultLo} !== '0) begin
      errs++;
      $display("FAIL reset_mid: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               Busy, Done, DivZero, ResultHi, ResultLo);
    end
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (Done !== 1'b0 || Busy !== 1'b0) n_act++;
    end
    vecs++;
    if (n_act !== 0) begin
      errs++;
      $display("FAIL reset_mid_no_done: got %0d active cycles want 0", n_act);
    end
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    MdOp  = 2'b00;
    SrcA  = '0;
    SrcB  = '0;
    test_reset();
    test_mul_timing();
    test_multiply();
    test_divide();
    test_hold();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
